// File: rtl/fn_sweep_if.sv
// Bus bundle between the sweep checker and its environment.
// The checker connects to the slave modport: it receives start and the F response
// (f_in), and it drives the input vector and the sweep results.
// The environment connects to the master modport. That is the block under check
// plus whatever issues start.
interface fn_sweep_if;
    logic       start;
    logic       f_in;
    logic       w;
    logic       x;
    logic       y;
    logic       z;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] first_err_idx;

    modport slave (
        input  start,
        input  f_in,
        output w,
        output x,
        output y,
        output z,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_err_idx
    );

    modport master (
        output start,
        output f_in,
        input  w,
        input  x,
        input  y,
        input  z,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_err_idx
    );
endinterface

// File: rtl/fn_sweep_checker.sv
// fn_sweep_checker: clocked exhaustive checker for a 4-input combinational function F.
// Drives the 16 vectors {w,x,y,z} = 0..15 in order. Each vector is held for
// SETTLE_CYCLES+1 cycles, and f_in is sampled in the vector's last cycle. The
// sampled value is compared with TRUTH_TABLE[idx]. At the end of the sweep the
// checker reports the mismatch count, the first failing index and pass/fail.
// Optional feature macro: FN_SWEEP_STOP_ON_ERR_EN. When it is defined, the sweep
// ends at the first mismatch.
module fn_sweep_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] TRUTH_TABLE   = 16'h1F55
) (
    input  logic        clk,
    input  logic        rst,
    fn_sweep_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    // Last settle count before sampling. A vector spends CNT_LAST+1 cycles in
    // SETTLE and one cycle in SAMPLE.
    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] err_q, err_d;
    logic [3:0] first_q, first_d;
    logic       pass_q, pass_d;
    logic       busy_q, busy_d;

    logic       expected_bit;
    logic       mismatch;
    logic [4:0] err_inc;

    // Golden value for the vector currently on w,x,y,z. It is only used in SAMPLE,
    // so glitches on f_in during settling are never seen.
    assign expected_bit = TRUTH_TABLE[idx_q];
    assign mismatch     = (bus.f_in != expected_bit);
    assign err_inc      = err_q + 5'd1;

    // Next-state and result update logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        first_d = first_q;
        pass_d  = pass_q;
        busy_d  = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    idx_d   = 4'd0;
                    cnt_d   = 4'd0;
                    err_d   = 5'd0;
                    first_d = 4'hF;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SETTLE;
                end
            end

            S_SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end
            end

            S_SAMPLE: begin
                if (mismatch) begin
                    // Five bits hold 16, so this increment cannot overflow.
                    err_d = err_inc;
                    if (err_q == 5'd0) begin
                        first_d = idx_q;
                    end
                end
`ifdef FN_SWEEP_STOP_ON_ERR_EN
                if (mismatch) begin
                    // Abort on the first failure. idx is held, so the failing
                    // vector stays visible on w,x,y,z through FIN.
                    pass_d  = 1'b0;
                    state_d = S_FIN;
                end else
`endif
                if (idx_q == 4'hF) begin
                    // Set pass here so that it is already valid in the done cycle.
                    pass_d  = mismatch ? 1'b0 : (err_q == 5'd0);
                    state_d = S_FIN;
                end else begin
                    // The next vector appears on the SAMPLE->SETTLE edge.
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = 4'd0;
                    state_d = S_SETTLE;
                end
            end

            S_FIN: begin
                // done is asserted in this cycle. The vector returns to 0 in IDLE.
                // start is not examined here, so a start coinciding with done is dropped.
                busy_d  = 1'b0;
                idx_d   = 4'd0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset. rst overrides start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            err_q   <= 5'd0;
            first_q <= 4'hF;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            first_q <= first_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
        end
    end

    // The vector outputs come straight from the registered index, so they
    // change only on clock edges.
    assign bus.w             = idx_q[3];
    assign bus.x             = idx_q[2];
    assign bus.y             = idx_q[1];
    assign bus.z             = idx_q[0];
    assign bus.busy          = busy_q;
    assign bus.done          = (state_q == S_FIN);
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_q;
    assign bus.first_err_idx = first_q;

endmodule

// File: tb/tb_fn_sweep_checker.sv
// Testbench for fn_sweep_checker (default build, SETTLE_CYCLES=2).
// The bench models the block under check: the golden table, optionally with faults.
// Expected sweep results are pushed to a queue when start is driven, and they are
// popped and compared when done is seen.
module tb_fn_sweep_checker;

    localparam int          SC   = 2;
    localparam logic [15:0] TT   = 16'h1F55;
    localparam int          LAT  = 16 * (SC + 1) + 1;

    typedef struct {
        int err;
        int first;
        int pass;
        int done_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   f_mode;
    int   n_cmp;
    int   n_bad;
    exp_t sb_q[$];

    fn_sweep_if bus ();

    fn_sweep_checker #(
        .SETTLE_CYCLES (SC),
        .TRUTH_TABLE   (TT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The behavioural F block. Mode 0 is correct, mode 1 is stuck at 0, and
    // mode 2 has the response for index 13 inverted.
    always_comb begin
        logic [15:0] tt_v;
        logic [3:0]  v;
        tt_v = TT;
        v    = {bus.w, bus.x, bus.y, bus.z};
        bus.f_in = tt_v[v];
        if (f_mode == 1) bus.f_in = 1'b0;
        if (f_mode == 2 && v == 4'd13) bus.f_in = ~tt_v[v];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_done"},  bus.done, 0);
        check({tag, "_pass"},  bus.pass, 0);
        check({tag, "_err"},   bus.err_count, 0);
        check({tag, "_first"}, bus.first_err_idx, 15);
        check({tag, "_vec"},   {bus.w, bus.x, bus.y, bus.z}, 0);
    endtask

    // Compute the expected result for a fault mode from the table and the fault model.
    function automatic exp_t predict(input int mode);
        exp_t        e;
        logic [15:0] tt_v;
        logic        resp;
        tt_v = TT;
        e.err = 0;
        e.first = 15;
        for (int i = 0; i < 16; i++) begin
            resp = tt_v[i];
            if (mode == 1) resp = 1'b0;
            if (mode == 2 && i == 13) resp = ~tt_v[i];
            if (resp != tt_v[i]) begin
                if (e.err == 0) e.first = i;
                e.err++;
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        e.done_cyc = LAT;
        return e;
    endfunction

    // Run one sweep. If repulse is set, extra start pulses are driven at cycles 5
    // and 30, and again in the done cycle.
    task automatic run_sweep(input int mode, input bit repulse);
        int   done_cnt;
        exp_t e;
        f_mode = mode;
        sb_q.push_back(predict(mode));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        done_cnt = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc <= 48)
                check("vec", {bus.w, bus.x, bus.y, bus.z}, (cyc - 1) / (SC + 1));
            if (cyc == 1) check("busy_on", bus.busy, 1);
            if (bus.done) begin
                done_cnt++;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("done_cyc", cyc, e.done_cyc);
                    check("err_count", bus.err_count, e.err);
                    check("first_err", bus.first_err_idx, e.first);
                    check("pass", bus.pass, e.pass);
                    $display("sweep mode=%0d done@%0d err=%0d first=%0d pass=%0d",
                             mode, cyc, bus.err_count, bus.first_err_idx, bus.pass);
                end
                if (repulse) bus.start = 1'b1;
            end
            if (repulse && (cyc == 5 || cyc == 30)) bus.start = 1'b1;
            if (cyc == LAT + 1) begin
                check("busy_off", bus.busy, 0);
                check("vec_wrap", {bus.w, bus.x, bus.y, bus.z}, 0);
            end
            if (cyc == 55) begin
                check("idle_busy", bus.busy, 0);
                check("pass_hold", bus.pass, (mode == 0) ? 1 : 0);
            end
            tick();
            bus.start = 1'b0;
        end
        check("done_pulses", done_cnt, 1);
        if (sb_q.size() > 0) begin
            check("sb_left", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        f_mode = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_reset_vals("rst");

        run_sweep(0, 1'b0);
        run_sweep(1, 1'b0);
        run_sweep(2, 1'b0);
        run_sweep(0, 1'b1);

        // Assert reset partway through a sweep. No done pulse may follow.
        begin
            int dn;
            f_mode = 0;
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            for (int c = 1; c < 20; c++) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check_reset_vals("midrst");
            dn = 0;
            for (int c = 0; c < 60; c++) begin
                if (bus.done) dn++;
                tick();
            end
            check("midrst_nodone", dn, 0);
            $display("mid-sweep reset: done pulses after reset=%0d", dn);
        end

        // Drive rst and start in the same cycle. Reset takes priority.
        bus.start = 1'b1;
        rst = 1'b1;
        tick();
        bus.start = 1'b0;
        rst = 1'b0;
        tick();
        check("rst_start_busy", bus.busy, 0);
        $display("rst+start same cycle: busy=%0d", bus.busy);

        run_sweep(0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
